// File: rtl/wb_sram_bridge.sv
// rtl/wb_sram_bridge.sv - Wishbone classic slave bridging single 32-bit cycles onto a 1RW SRAM port
// Optional macro WB_SRAM_BRIDGE_ERR_EN: error response for out-of-range hits and empty-mask writes.
module wb_sram_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK    = 32'hFFFF_F000,
    parameter int          ADDR_W       = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_err_o,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [3:0]        sram_wmask0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [31:0]       sram_din0,
    input  logic [31:0]       sram_dout0
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RWAIT, S_ACK} state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dat_q, dat_d;
    logic              hit, req, accept;

    assign hit = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign req = wbs_cyc_i & wbs_stb_i & hit;

`ifdef WB_SRAM_BRIDGE_ERR_EN
    // Window bits above the SRAM word range; any set bit means the word does not exist.
    localparam logic [31:0] HI_MASK = ~ADDR_MASK & (32'hFFFF_FFFF << (ADDR_W + 2));

    logic bad, err_q, err_d;

    assign bad    = ((wbs_adr_i & HI_MASK) != 32'h0) | (wbs_we_i & (wbs_sel_i == 4'h0));
    // The cycle after an error the master is still dropping stb, so it is not a new request.
    assign accept = req & ~bad & ~err_q;
    assign err_d  = (state_q == S_IDLE) & req & bad & ~err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wbs_err_o = err_q;
`else
    assign accept    = req;
    assign wbs_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = wbs_adr_i[ADDR_W+1:2];
                    din_d   = wbs_dat_i;
                    csb_d   = 1'b0;
                    web_d   = ~wbs_we_i;
                    wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!web_q) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (cnt_q == 2'd0) begin
                    dat_d   = sram_dout0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'h0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dat_q   <= dat_d;
        end
    end

    // An aborted cycle still runs to completion; only the handshake is withheld.
    assign wbs_ack_o   = (state_q == S_ACK) & wbs_cyc_i;
    assign wbs_dat_o   = dat_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;
endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb/tb_wb_sram_bridge.sv - randomized bench for wb_sram_bridge against a cycle-expectation model
module tb_wb_sram_bridge;
    localparam int RL = 1;

    typedef struct packed {
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    wb_sram_bridge #(
        .BASE_ADDR(32'h3000_0000), .ADDR_MASK(32'hFFFF_F000), .ADDR_W(8), .READ_LATENCY(RL)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .wbs_err_o(wbs_err_o),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc_cnt = 0;

    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    logic [31:0] last_rd = 32'h0;
    cmd_t        exp_cmd [int];
    logic [31:0] exp_ack [int];
    bit          exp_err [int];
    cmd_t        cmp_c;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM macro stand-in: output is only meaningful the cycle after a read sample.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end else begin
            sram_dout0 <= $urandom;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_cnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ack",   32'(wbs_ack_o),   32'h0);
            chk("rst_err",   32'(wbs_err_o),   32'h0);
            chk("rst_dat",   wbs_dat_o,        32'h0);
            chk("rst_csb",   32'(sram_csb0),   32'h1);
            chk("rst_web",   32'(sram_web0),   32'h1);
            chk("rst_wmask", 32'(sram_wmask0), 32'h0);
            chk("rst_addr",  32'(sram_addr0),  32'h0);
            chk("rst_din",   sram_din0,        32'h0);
        end else begin
            if (exp_cmd.exists(cyc_cnt)) begin
                cmp_c = exp_cmd[cyc_cnt];
                chk("cmd_csb",   32'(sram_csb0),   32'h0);
                chk("cmd_web",   32'(sram_web0),   32'(cmp_c.web));
                chk("cmd_wmask", 32'(sram_wmask0), 32'(cmp_c.wmask));
                chk("cmd_addr",  32'(sram_addr0),  32'(cmp_c.addr));
                chk("cmd_din",   sram_din0,        cmp_c.din);
            end else begin
                chk("idle_csb", 32'(sram_csb0), 32'h1);
                chk("idle_web", 32'(sram_web0), 32'h1);
            end
            if (exp_ack.exists(cyc_cnt)) begin
                chk("ack", 32'(wbs_ack_o), 32'h1);
                chk("ack_dat", wbs_dat_o, exp_ack[cyc_cnt]);
            end else begin
                chk("no_ack", 32'(wbs_ack_o), 32'h0);
            end
            chk("err", 32'(wbs_err_o), 32'(exp_err.exists(cyc_cnt)));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] data,
                           input logic [3:0] sel, input bit abort,
                           output logic [31:0] rdata, output int lat);
        int e;
        int w;
        bit hit, bad, got;
        tick();
        hit = (adr & 32'hFFFF_F000) == 32'h3000_0000;
        w   = int'((adr >> 2) % 256);
        bad = 1'b0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
        bad = hit && ((((adr & 32'hFFF) >> 2) >= 256) || (we && sel == 4'h0));
`endif
        e = cyc_cnt + 1;
        if (hit && !bad) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[w][b*8 +: 8] = data[b*8 +: 8];
                exp_cmd[e] = {1'b0, sel, 8'(w), data};
                if (!abort) exp_ack[e + 1] = last_rd;
            end else begin
                last_rd = ref_mem[w];
                exp_cmd[e] = {1'b1, 4'h0, 8'(w), data};
                exp_ack[e + 1 + RL] = last_rd;
            end
        end else if (hit) begin
            exp_err[e] = 1'b1;
        end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = data;
        rdata = 32'h0; lat = 0; got = 1'b0;
        if (!hit) begin
            repeat (10) tick();
        end else if (abort) begin
            tick();
        end else begin
            for (int k = 0; k < 10; k++) begin
                tick();
                if (wbs_ack_o || wbs_err_o) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("handshake", 32'(got), 32'h1);
            lat   = cyc_cnt - e + 1;
            rdata = wbs_dat_o;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (abort) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, adr, data;
        logic [3:0]  sel;
        logic        we;
        int          lat, r, e;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        repeat (3) tick();
        rst = 1'b0;

        wb_xfer(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat);
        chk("write_latency", 32'(lat), 32'd2);
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_deadbeef", rd, 32'hDEAD_BEEF);

        wb_xfer(1'b1, 32'h3000_0004, 32'h1111_1111, 4'hF, 1'b0, rd, lat);
        wb_xfer(1'b1, 32'h3000_0004, 32'h0000_AB00, 4'b0010, 1'b0, rd, lat);
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("byte_write", rd, 32'h1111_AB11);

        wb_xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b0, rd, lat);

        tick();
        e = cyc_cnt + 1;
        exp_cmd[e] = {1'b1, 4'h0, 8'h00, 32'h0};
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'h0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_csb", 32'(sram_csb0), 32'h1);
        chk("rst_mid_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_mid_dat", wbs_dat_o, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        exp_cmd.delete(); exp_ack.delete(); exp_err.delete();
        last_rd = 32'h0;
        tick();
        rst = 1'b0;
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("read_after_rst", rd, 32'hDEAD_BEEF);

        wb_xfer(1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
`ifdef WB_SRAM_BRIDGE_ERR_EN
        chk("oor_err_latency", 32'(lat), 32'd1);
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("oor_word0_kept", rd, 32'hDEAD_BEEF);
`else
        chk("alias_latency", 32'(lat), 32'd2);
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("alias_word0", rd, 32'h1234_5678);
`endif

        for (int i = 0; i < 400; i++) begin
            r    = int'($urandom_range(0, 99));
            we   = 1'($urandom_range(0, 1));
            data = $urandom;
            sel  = 4'($urandom_range(0, 15));
            if (r < 8) begin
                adr = $urandom;
                if ((adr & 32'hFFFF_F000) == 32'h3000_0000) adr = adr ^ 32'h1000_0000;
            end else if (r % 2 == 0) begin
                adr = {20'h30000, 10'($urandom_range(0, 15)), 2'b00};
            end else begin
                adr = {20'h30000, 10'($urandom_range(0, 1023)), 2'b00};
            end
            wb_xfer(we, adr, data, sel, we && (r >= 95), rd, lat);
        end

        repeat (3) tick();
        for (int i = 0; i < 256; i++) chk("mem_word", sram_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
